gate_vector_sequencer: RTL and testbench

- Hardware sequencer that exercises a 2-input gate under test (e.g. the XOR cell) from a stored vector table.
- Fetches 3-bit vectors {a, b, expected_y} from a synchronous-read vector memory and drives a/b into the gate.
- Waits a settle interval, then compares the gate output against expected and counts mismatches.
- Sits between the vector ROM and the gate; replaces bench-side sequencing so the same check runs on silicon/FPGA.

---
 rtl/gate_vector_sequencer.sv | 169 ++++++++++++++++
 tb/tb_gate_vector_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_sequencer.sv
// Drives a 2-input gate under test from a synchronous-read vector table and counts output mismatches.
// Optional define GATE_SEQ_FIRST_FAIL_EN adds capture of the first failing vector of each run.
module gate_vector_sequencer #(
    parameter int NUM_VECTORS   = 24,
    parameter int IDX_W         = 11,
    parameter int ERR_W         = 11,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [IDX_W-1:0] vec_addr_o,
    input  logic [2:0]       vec_data_i,
    output logic             dut_a_o,
    output logic             dut_b_o,
    input  logic             dut_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [IDX_W-1:0] vector_index_o,
    output logic [ERR_W-1:0] error_count_o
`ifdef GATE_SEQ_FIRST_FAIL_EN
    ,
    output logic             first_fail_valid_o,
    output logic [IDX_W-1:0] first_fail_index_o,
    output logic [2:0]       first_fail_vec_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] vec_addr_q, vec_addr_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       settle_q, settle_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             exp_q, exp_d;
`ifdef GATE_SEQ_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [IDX_W-1:0] ff_index_q, ff_index_d;
    logic [2:0]       ff_vec_q, ff_vec_d;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            vec_addr_q <= '0;
            index_q    <= '0;
            err_q      <= '0;
            settle_q   <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            exp_q      <= 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
            ff_valid_q <= 1'b0;
            ff_index_q <= '0;
            ff_vec_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vec_addr_q <= vec_addr_d;
            index_q    <= index_d;
            err_q      <= err_d;
            settle_q   <= settle_d;
            a_q        <= a_d;
            b_q        <= b_d;
            exp_q      <= exp_d;
`ifdef GATE_SEQ_FIRST_FAIL_EN
            ff_valid_q <= ff_valid_d;
            ff_index_q <= ff_index_d;
            ff_vec_q   <= ff_vec_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_addr_d = vec_addr_q;
        index_d    = index_q;
        err_d      = err_q;
        settle_d   = settle_q;
        a_d        = a_q;
        b_d        = b_q;
        exp_d      = exp_q;
`ifdef GATE_SEQ_FIRST_FAIL_EN
        ff_valid_d = ff_valid_q;
        ff_index_d = ff_index_q;
        ff_vec_d   = ff_vec_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d    = ST_FETCH;
                    index_d    = '0;
                    err_d      = '0;
                    vec_addr_d = '0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
                    ff_valid_d = 1'b0;
                    ff_index_d = '0;
                    ff_vec_d   = '0;
`endif
                end
            end
            ST_FETCH: state_d = ST_APPLY;
            ST_APPLY: begin
                // Memory data for vec_addr presented during FETCH is valid now.
                {a_d, b_d, exp_d} = vec_data_i;
                settle_d          = SETTLE_INIT;
                state_d           = ST_SETTLE;
            end
            ST_SETTLE: begin
                settle_d = settle_q - 8'd1;
                if (settle_q <= 8'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (dut_y_i != exp_q) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
`ifdef GATE_SEQ_FIRST_FAIL_EN
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_index_d = index_q;
                        ff_vec_d   = {a_q, b_q, dut_y_i};
                    end
`endif
                end
                if (index_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d    = index_q + IDX_W'(1);
                    vec_addr_d = index_q + IDX_W'(1);
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign vec_addr_o     = vec_addr_q;
    assign dut_a_o        = a_q;
    assign dut_b_o        = b_q;
    assign busy_o         = (state_q == ST_FETCH) || (state_q == ST_APPLY) ||
                            (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done_o         = (state_q == ST_DONE);
    assign pass_o         = (state_q == ST_DONE) && (err_q == '0);
    assign vector_index_o = index_q;
    assign error_count_o  = err_q;
`ifdef GATE_SEQ_FIRST_FAIL_EN
    assign first_fail_valid_o = ff_valid_q;
    assign first_fail_index_o = ff_index_q;
    assign first_fail_vec_o   = ff_vec_q;
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: a 24-vector instance for the main runs and a small
// 4-vector / S=3 / 2-bit-counter instance for settle timing and saturation.
module tb_gate_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Instance 0: N=24, S=1, ERR_W=11
    logic        start0;
    logic [10:0] addr0, idx0;
    logic [2:0]  rdata0;
    logic        a0, b0, y0, busy0, done0, pass0;
    logic [10:0] err0;
    int          mode0;
    logic [2:0]  mem0 [0:2047];
    logic        ffv0;
    logic [10:0] ffi0;
    logic [2:0]  ffvec0;

    // Instance 1: N=4, S=3, ERR_W=2
    logic        start1;
    logic [10:0] addr1, idx1;
    logic [2:0]  rdata1;
    logic        a1, b1, y1, busy1, done1, pass1;
    logic [1:0]  err1;
    int          mode1;
    logic [2:0]  mem1 [0:2047];
    logic        ffv1;
    logic [10:0] ffi1;
    logic [2:0]  ffvec1;

    function automatic logic gate_f(int mode, logic a, logic b);
        case (mode)
            0:       return a ^ b;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~(a ^ b);
        endcase
    endfunction

    always @(posedge clk) rdata0 <= mem0[addr0];
    always @(posedge clk) rdata1 <= mem1[addr1];
    assign y0 = gate_f(mode0, a0, b0);
    assign y1 = gate_f(mode1, a1, b1);

    gate_vector_sequencer #(.NUM_VECTORS(24), .IDX_W(11), .ERR_W(11), .SETTLE_CYCLES(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .vec_addr_o(addr0), .vec_data_i(rdata0),
        .dut_a_o(a0), .dut_b_o(b0), .dut_y_i(y0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .vector_index_o(idx0), .error_count_o(err0)
`ifdef GATE_SEQ_FIRST_FAIL_EN
        , .first_fail_valid_o(ffv0), .first_fail_index_o(ffi0), .first_fail_vec_o(ffvec0)
`endif
    );

    gate_vector_sequencer #(.NUM_VECTORS(4), .IDX_W(11), .ERR_W(2), .SETTLE_CYCLES(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .vec_addr_o(addr1), .vec_data_i(rdata1),
        .dut_a_o(a1), .dut_b_o(b1), .dut_y_i(y1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .vector_index_o(idx1), .error_count_o(err1)
`ifdef GATE_SEQ_FIRST_FAIL_EN
        , .first_fail_valid_o(ffv1), .first_fail_index_o(ffi1), .first_fail_vec_o(ffvec1)
`endif
    );

`ifndef GATE_SEQ_FIRST_FAIL_EN
    assign ffv0 = 1'b0; assign ffi0 = '0; assign ffvec0 = '0;
    assign ffv1 = 1'b0; assign ffi1 = '0; assign ffvec1 = '0;
`endif

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Pulses start on instance 0 and counts edges (start edge = 1) until done.
    // mid_start_at > 0 raises start for one cycle at that edge count while busy.
    task automatic run0(input int mid_start_at, output int n, output bit busy_ok);
        busy_ok = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 1;
        if (!busy0 || done0) busy_ok = 1'b0;
        while (!done0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            start0 = (n == mid_start_at);
            if (!done0 && !busy0) busy_ok = 1'b0;
            if (done0 && busy0) busy_ok = 1'b0;
        end
        start0 = 1'b0;
        if (!done0) begin
            $display("FAIL run0_timeout actual=%0d required=done", n);
            bad++;
            total++;
        end
    endtask

    function automatic void xor_table0();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            mem0[i] = {ab[1], ab[0], ab[1] ^ ab[0]};
        end
    endfunction

    typedef struct {
        int         gate_mode;
        int         exp_err;
        bit         exp_pass;
        int         exp_ff_idx;
        logic [2:0] exp_ff_vec;
    } vec_case_t;

    initial begin
        vec_case_t  cases [4];
        int         n, cnt, ff_idx, ab_n, err_n, k;
        bit         busy_ok;
        logic [2:0] ff_vec;
        logic [1:0] prev_ab;
        logic [1:0] prev_err1;
        int         ab_edges [$];
        int         err_edges [$];

        cases[0] = '{0,  0, 1'b1, -1, 3'b000};
        cases[1] = '{1, 12, 1'b0,  1, 3'b010};
        cases[2] = '{2, 12, 1'b0,  0, 3'b001};
        cases[3] = '{3, 24, 1'b0,  0, 3'b001};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode0 = 0; mode1 = 3;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        xor_table0();
        mem1[0] = 3'b011; mem1[1] = 3'b101; mem1[2] = 3'b110; mem1[3] = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs0", {addr0, a0, b0, busy0, done0, pass0, idx0, err0}, 0);
        chk("reset_outputs1", {addr1, a1, b1, busy1, done1, pass1, idx1, err1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_activity", {busy0, done0, addr0}, 0);

        // Table-driven runs against the XOR table
        foreach (cases[c]) begin
            mode0 = cases[c].gate_mode;
            run0(0, n, busy_ok);
            $display("case %0d mode=%0d edges=%0d err=%0d pass=%0d", c, mode0, n, err0, pass0);
            chk("tbl_done_edge", n, 97);
            chk("tbl_busy", busy_ok, 1);
            chk("tbl_err", err0, cases[c].exp_err);
            chk("tbl_pass", pass0, cases[c].exp_pass);
            chk("tbl_index", idx0, 23);
`ifdef GATE_SEQ_FIRST_FAIL_EN
            chk("tbl_ff_valid", ffv0, cases[c].exp_ff_idx >= 0);
            if (cases[c].exp_ff_idx >= 0) begin
                chk("tbl_ff_idx", ffi0, cases[c].exp_ff_idx);
                chk("tbl_ff_vec", ffvec0, cases[c].exp_ff_vec);
            end
`endif
        end

        // Failing run with an ignored mid-run start, then restart from DONE with a good gate
        mode0 = 1;
        run0(40, n, busy_ok);
        $display("ignored_start run edges=%0d err=%0d", n, err0);
        chk("ignstart_done_edge", n, 97);
        chk("ignstart_err", err0, 12);
        chk("ignstart_pass", pass0, 0);
        mode0 = 0;
        run0(0, n, busy_ok);
        $display("restart run edges=%0d err=%0d pass=%0d", n, err0, pass0);
        chk("restart_busy", busy_ok, 1);
        chk("restart_done_edge", n, 97);
        chk("restart_err", err0, 0);
        chk("restart_pass", pass0, 1);

        // Randomized tables and gates against the model
        for (int it = 0; it < 6; it++) begin
            mode0 = int'($urandom_range(0, 3));
            for (int i = 0; i < 24; i++) mem0[i] = 3'($urandom_range(0, 7));
            cnt = 0; ff_idx = -1; ff_vec = '0;
            for (int i = 0; i < 24; i++) begin
                logic [2:0] v;
                logic       y;
                v = mem0[i];
                y = gate_f(mode0, v[2], v[1]);
                if (y != v[0]) begin
                    cnt++;
                    if (ff_idx < 0) begin
                        ff_idx = i;
                        ff_vec = {v[2], v[1], y};
                    end
                end
            end
            run0(0, n, busy_ok);
            $display("random %0d mode=%0d err=%0d model=%0d", it, mode0, err0, cnt);
            chk("rand_done_edge", n, 97);
            chk("rand_err", err0, cnt);
            chk("rand_pass", pass0, cnt == 0);
`ifdef GATE_SEQ_FIRST_FAIL_EN
            chk("rand_ff_valid", ffv0, cnt != 0);
            if (cnt != 0) begin
                chk("rand_ff_idx", ffi0, ff_idx);
                chk("rand_ff_vec", ffvec0, ff_vec);
            end
`endif
        end

        // Settle timing and saturation on the small instance (S=3, all vectors mismatch)
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 1;
        prev_ab = {a1, b1};
        prev_err1 = err1;
        while (!done1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if ({a1, b1} != prev_ab) ab_edges.push_back(n);
            if (err1 != prev_err1) err_edges.push_back(n);
            prev_ab = {a1, b1};
            prev_err1 = err1;
        end
        $display("small run edges=%0d err=%0d ab_changes=%0d err_changes=%0d",
                 n, err1, ab_edges.size(), err_edges.size());
        chk("small_done_edge", n, 1 + 4 * (3 + 3));
        chk("small_err_sat", err1, 3);
        chk("small_pass", pass1, 0);
        chk("small_index", idx1, 3);
        ab_n = ab_edges.size();
        err_n = err_edges.size();
        chk("small_ab_changes", ab_n, 4);
        chk("small_err_changes", err_n, 3);
        for (k = 0; k < ab_n && k < 4; k++) chk("small_apply_edge", ab_edges[k], 3 + 6 * k);
        for (k = 0; k < err_n && k < 3; k++) chk("small_check_edge", err_edges[k], 7 + 6 * k);
`ifdef GATE_SEQ_FIRST_FAIL_EN
        chk("small_ff_idx", ffi1, 0);
        chk("small_ff_vec", ffvec1, 3'b010);
`endif

        // Asynchronous reset in the middle of vector 10
        mode0 = 0;
        xor_table0();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        while (idx0 != 11'd10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("async_reached_v10", idx0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset applied at t=%0t", $time);
        chk("async_rst_outputs", {addr0, a0, b0, busy0, done0, pass0, idx0, err0}, 0);
        chk("async_rst_small", {busy1, done1, err1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", {busy0, done0, addr0, idx0}, 0);
        run0(0, n, busy_ok);
        $display("post reset run edges=%0d err=%0d pass=%0d", n, err0, pass0);
        chk("post_rst_done_edge", n, 97);
        chk("post_rst_pass", pass0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
